// File: rtl/reg_file_cc.sv
// reg_file_cc: operand-fetch / writeback stage feeding the ALU.
// Eight general-purpose registers, SR2/imm5 operand mux, NZP condition
// codes and the BEN branch-enable flag.
// Optional macro READ_BYPASS_EN: forwards the writeback bus onto a read
// port whose select matches dr while ld_reg is high.
module reg_file_cc #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int IMM_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] bus,
    input  logic              ld_reg,
    input  logic [ADDR_W-1:0] dr,
    input  logic [ADDR_W-1:0] sr1,
    input  logic [ADDR_W-1:0] sr2,
    input  logic              sr2mux,
    input  logic [DATA_W-1:0] ir,
    input  logic              ld_cc,
    input  logic              ld_ben,
    output logic [DATA_W-1:0] one,
    output logic [DATA_W-1:0] two,
    output logic [2:0]        nzp,
    output logic              ben
);

    localparam int NREG = 2 ** ADDR_W;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm_sext;
    logic [2:0]        cc_next;

    // Only the branch mask and the immediate field of ir are consumed here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[DATA_W-1:12], ir[8:IMM_W]};

    // Register array: asynchronous clear, single write port driven by the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this storage is architecturally visible after reset, so every
            // entry is cleared; an unreset array would read X until first written.
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (ld_reg) begin
            // NOTE: non-blocking assignment keeps every read in this edge seeing
            // the pre-edge contents, which is what the same-cycle read relies on.
            regs[dr] <= bus;
        end
    end

    // Condition code decode from the bus: negative, zero or positive, one-hot.
    always_comb begin
        // NOTE: default first so every path assigns cc_next and no latch forms.
        cc_next = CC_P;
        if (bus[DATA_W-1]) begin
            cc_next = CC_N;
        end else if (bus == '0) begin
            cc_next = CC_Z;
        end
    end

    // NZP and BEN registers; BEN samples the nzp held before this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nzp <= CC_Z;
            ben <= 1'b0;
        end else begin
            if (ld_cc) begin
                nzp <= cc_next;
            end
            if (ld_ben) begin
                ben <= |(ir[11:9] & nzp);
            end
        end
    end

`ifdef READ_BYPASS_EN
    // Write-before-read forwarding: a matching read port sees the bus directly.
    always_comb begin
        rd1 = regs[sr1];
        rd2 = regs[sr2];
        if (ld_reg && (sr1 == dr)) begin
            rd1 = bus;
        end
        if (ld_reg && (sr2 == dr)) begin
            rd2 = bus;
        end
    end
`else
    // Plain combinational reads of the stored contents.
    always_comb begin
        rd1 = regs[sr1];
        rd2 = regs[sr2];
    end
`endif

    // Operand formation: sign-extended imm5 or SR2 on the second operand.
    always_comb begin
        imm_sext = {{(DATA_W - IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
        one      = rd1;
        two      = sr2mux ? imm_sext : rd2;
    end

endmodule
